// File: rtl/custom_axi_ip_regs.sv
//-----------------------------------------------------------------------------
// custom_axi_ip_regs
//
// AXI4-Lite slave register block in front of a simple hardware core.
//
// Register map (byte address, addr[1:0] ignored):
//   0x00 CTRL   bit0 START (write 1 -> one-cycle enable_in_o pulse, reads 0)
//               bit1 IRQ_EN (only with CUSTOM_AXI_IP_REGS_IRQ_EN, else reads 0)
//   0x04 DIN    bits[15:0] RW, drives din_o; bits[31:16] read 0
//   0x08 DOUT   RO, captures dout_i whenever enable_out_i[0] is high
//   0x0C STATUS [1:0] live status_i, [2] DONE sticky, [3] OVERRUN sticky,
//               [3:2] write-1-to-clear; a set on the same cycle wins
//   0x10-0x1C   unmapped: writes ignored, SLVERR on both channels
//
// Ports:
//   clk_i, rst_i            clock and asynchronous active-high reset
//   s_axi_aw*/w*/b*         AXI4-Lite write address/data/response channels
//   s_axi_ar*/r*            AXI4-Lite read address/data channels
//   din_o, enable_in_o      operand and start pulse to the core
//   dout_i, enable_out_i    result and result-valid strobe (bit0) from core
//   status_i                core state (0 IDLE, 1 BUSY, 2 DONE, 3 ERROR)
//   irq_o                   only when CUSTOM_AXI_IP_REGS_IRQ_EN is defined:
//                           registered IRQ_EN AND DONE
//
// Build option: define CUSTOM_AXI_IP_REGS_IRQ_EN to add irq_o and CTRL.IRQ_EN.
//-----------------------------------------------------------------------------
module custom_axi_ip_regs #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [15:0]             din_o,
  output logic                    enable_in_o,
  input  logic [15:0]             dout_i,
  input  logic [1:0]              enable_out_i,
  input  logic [1:0]              status_i
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_DIN    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_DOUT   = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_LIMIT  = IDX_W'(4);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_ADDR = 2'd1;  // AW held, waiting for W
  localparam logic [1:0] WR_DATA = 2'd2;  // W held, waiting for AW
  localparam logic [1:0] WR_RESP = 2'd3;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_RESP = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]              wr_state_reg, wr_state_next;
  logic [0:0]              rd_state_reg;
  logic [ADDR_WIDTH-1:0]   awaddr_hold_reg;
  logic [DATA_WIDTH-1:0]   wdata_hold_reg;
  logic [DATA_WIDTH/8-1:0] wstrb_hold_reg;
  logic                    bvalid_reg;
  logic [1:0]              bresp_reg;
  logic                    rvalid_reg;
  logic [1:0]              rresp_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [15:0]             din_reg, din_next;
  logic [15:0]             dout_reg;
  logic                    done_reg, overrun_reg;
  logic                    enable_in_reg;
  logic                    ctrl_irq_en;

  // ---------------------------------------------------------------------------
  // Handshakes. Readies are a pure function of state, masked while in reset.
  // ---------------------------------------------------------------------------
  assign s_axi_awready = !rst_i && ((wr_state_reg == WR_IDLE) || (wr_state_reg == WR_DATA));
  assign s_axi_wready  = !rst_i && ((wr_state_reg == WR_IDLE) || (wr_state_reg == WR_ADDR));
  assign s_axi_arready = !rst_i && (rd_state_reg == RD_IDLE);

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // ---------------------------------------------------------------------------
  // Write FSM. commit is high on the cycle both halves are available; the
  // half that arrived earlier comes from its hold register.
  // ---------------------------------------------------------------------------
  logic commit;

  always_comb begin
    wr_state_next = wr_state_reg;
    commit        = 1'b0;
    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_next = WR_RESP;
          commit        = 1'b1;
        end else if (aw_hs) begin
          wr_state_next = WR_ADDR;
        end else if (w_hs) begin
          wr_state_next = WR_DATA;
        end
      end
      WR_ADDR: begin
        if (w_hs) begin
          wr_state_next = WR_RESP;
          commit        = 1'b1;
        end
      end
      WR_DATA: begin
        if (aw_hs) begin
          wr_state_next = WR_RESP;
          commit        = 1'b1;
        end
      end
      default: begin
        if (s_axi_bready) wr_state_next = WR_IDLE;
      end
    endcase
  end

  logic [ADDR_WIDTH-1:0]   wr_addr_eff;
  logic [DATA_WIDTH-1:0]   wr_data_eff;
  logic [DATA_WIDTH/8-1:0] wr_strb_eff;
  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_mapped;
  logic                    wr_sel_ctrl, wr_sel_din, wr_sel_status;

  assign wr_addr_eff = (wr_state_reg == WR_ADDR) ? awaddr_hold_reg : s_axi_awaddr;
  assign wr_data_eff = (wr_state_reg == WR_DATA) ? wdata_hold_reg  : s_axi_wdata;
  assign wr_strb_eff = (wr_state_reg == WR_DATA) ? wstrb_hold_reg  : s_axi_wstrb;
  assign wr_idx      = wr_addr_eff[ADDR_WIDTH-1:2];
  assign wr_mapped   = (wr_idx < IDX_LIMIT);

  assign wr_sel_ctrl   = commit && (wr_idx == IDX_CTRL);
  assign wr_sel_din    = commit && (wr_idx == IDX_DIN);
  assign wr_sel_status = commit && (wr_idx == IDX_STATUS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_reg    <= WR_IDLE;
      awaddr_hold_reg <= '0;
      wdata_hold_reg  <= '0;
      wstrb_hold_reg  <= '0;
      bvalid_reg      <= 1'b0;
      bresp_reg       <= RESP_OKAY;
    end else begin
      wr_state_reg <= wr_state_next;
      if (aw_hs) awaddr_hold_reg <= s_axi_awaddr;
      if (w_hs) begin
        wdata_hold_reg <= s_axi_wdata;
        wstrb_hold_reg <= s_axi_wstrb;
      end
      if (commit) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  assign s_axi_bvalid = bvalid_reg;
  assign s_axi_bresp  = bresp_reg;

  // ---------------------------------------------------------------------------
  // Core-facing registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_din_byte
      assign din_next[gi*8 +: 8] = (wr_sel_din && wr_strb_eff[gi]) ?
                                   wr_data_eff[gi*8 +: 8] : din_reg[gi*8 +: 8];
    end
  endgenerate

  logic result_strobe;
  logic clear_done, clear_overrun;

  assign result_strobe = enable_out_i[0];
  assign clear_done    = wr_sel_status && wr_strb_eff[0] && wr_data_eff[2];
  assign clear_overrun = wr_sel_status && wr_strb_eff[0] && wr_data_eff[3];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      din_reg       <= '0;
      dout_reg      <= '0;
      done_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
      enable_in_reg <= 1'b0;
    end else begin
      din_reg       <= din_next;
      enable_in_reg <= wr_sel_ctrl && wr_strb_eff[0] && wr_data_eff[0];
      if (result_strobe) dout_reg <= dout_i;
      // Hardware set takes priority over a software clear in the same cycle.
      if (result_strobe)   done_reg <= 1'b1;
      else if (clear_done) done_reg <= 1'b0;
      // OVERRUN looks at DONE as it was before this strobe.
      if (result_strobe && done_reg) overrun_reg <= 1'b1;
      else if (clear_overrun)        overrun_reg <= 1'b0;
    end
  end

  assign din_o       = din_reg;
  assign enable_in_o = enable_in_reg;

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  logic irq_en_reg, irq_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_sel_ctrl && wr_strb_eff[0]) irq_en_reg <= wr_data_eff[1];
      irq_reg <= irq_en_reg && done_reg;
    end
  end

  assign ctrl_irq_en = irq_en_reg;
  assign irq_o       = irq_reg;
`else
  assign ctrl_irq_en = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path. rdata is sampled from the current register values at the AR
  // handshake, so a write committing on the same edge is not yet visible.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data_mux;
  logic [1:0]            rd_resp_mux;

  assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:2];

  always_comb begin
    rd_data_mux = '0;
    rd_resp_mux = RESP_OKAY;
    case (rd_idx)
      IDX_CTRL:   rd_data_mux[1]    = ctrl_irq_en;
      IDX_DIN:    rd_data_mux[15:0] = din_reg;
      IDX_DOUT:   rd_data_mux[15:0] = dout_reg;
      IDX_STATUS: rd_data_mux[3:0]  = {overrun_reg, done_reg, status_i};
      default:    rd_resp_mux       = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_reg <= RD_IDLE;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      if (ar_hs) begin
        rd_state_reg <= RD_RESP;
        rvalid_reg   <= 1'b1;
        rdata_reg    <= rd_data_mux;
        rresp_reg    <= rd_resp_mux;
      end else if ((rd_state_reg == RD_RESP) && s_axi_rready) begin
        rd_state_reg <= RD_IDLE;
        rvalid_reg   <= 1'b0;
      end
    end
  end

  assign s_axi_rvalid = rvalid_reg;
  assign s_axi_rdata  = rdata_reg;
  assign s_axi_rresp  = rresp_reg;

  // Address LSBs, upper data/strobe lanes and enable_out_i[1] carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{wr_data_eff, wr_strb_eff, wr_addr_eff[1:0],
                         s_axi_araddr[1:0], enable_out_i[1]};

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
module tb_custom_axi_ip_regs;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [4:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [15:0] din_o;
  logic        enable_in_o;
  logic [15:0] dout_i = '0;
  logic [1:0]  enable_out_i = '0;
  logic [1:0]  status_i = '0;
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
  logic        irq_o;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  custom_axi_ip_regs #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .din_o(din_o), .enable_in_o(enable_in_o), .dout_i(dout_i),
    .enable_out_i(enable_out_i), .status_i(status_i)
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;

  // Reference model of the register file contents.
  logic [15:0] m_din  = '0;
  logic [15:0] m_dout = '0;
  logic        m_done = 1'b0;
  logic        m_ovr  = 1'b0;
  logic        m_irq_en = 1'b0;

  always @(negedge clk_i) if (enable_in_o === 1'b1) en_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [33:0] model_read(input logic [4:0] a);
    int idx;
    idx = int'(a) / 4;
    case (idx)
      0:       return {2'b00, 30'd0, m_irq_en, 1'b0};
      1:       return {2'b00, 16'd0, m_din};
      2:       return {2'b00, 16'd0, m_dout};
      3:       return {2'b00, 28'd0, m_ovr, m_done, status_i};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a) / 4;
    if (idx == 0 && s[0] && IRQ_BUILT) m_irq_en = d[1];
    if (idx == 1) begin
      if (s[0]) m_din[7:0]  = d[7:0];
      if (s[1]) m_din[15:8] = d[15:8];
    end
    if (idx == 3 && s[0]) begin
      if (d[2]) m_done = 1'b0;
      if (d[3]) m_ovr  = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_din = '0; m_dout = '0; m_done = 1'b0; m_ovr = 1'b0; m_irq_en = 1'b0;
  endtask

  task automatic model_strobe(input logic [15:0] d);
    if (m_done) m_ovr = 1'b1;
    m_done = 1'b1;
    m_dout = d;
  endtask

  // Full write transaction; AW/W presented after the given cycle offsets.
  task automatic wr_chk(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_start, input int w_start, input int b_delay);
    bit aw_done = 0, w_done = 0, aw_go, w_go;
    int cyc = 0, en0;
    logic [1:0] exp_resp;
    bit exp_start;
    exp_resp  = (int'(a) / 4 >= 4) ? 2'b10 : 2'b00;
    exp_start = (int'(a) / 4 == 0) && s[0] && d[0];
    en0 = en_cnt;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_start) s_axi_awvalid = 1'b1;
      if (!w_done && cyc >= w_start) s_axi_wvalid = 1'b1;
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_go) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_go)  begin w_done = 1;  s_axi_wvalid  = 1'b0; end
      cyc++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("wr_handshake", 32'(aw_done && w_done), 32'd1);
    chk("wr_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("wr_start_pulse", 32'(enable_in_o), 32'(exp_start));
    chk("wr_bresp", 32'(s_axi_bresp), 32'(exp_resp));
    for (int i = 0; i < b_delay; i++) begin
      tick();
      chk("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
      chk("b_hold_resp", 32'(s_axi_bresp), 32'(exp_resp));
      chk("b_hold_readies", 32'({s_axi_awready, s_axi_wready}), 32'd0);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("wr_bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    chk("wr_start_count", 32'(en_cnt - en0), 32'(exp_start));
    model_write(a, d, s);
    chk("din_o", 32'(din_o), 32'(m_din));
    $display("WR addr=0x%02h data=0x%08h strb=%b aw@%0d w@%0d bresp=%b", a, d, s, aw_start, w_start, s_axi_bresp);
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                        input int r_delay);
    bit done = 0, go;
    int cyc = 0;
    s_axi_araddr = a;
    while (!done && cyc < 40) begin
      s_axi_arvalid = 1'b1;
      go = s_axi_arready;
      tick();
      if (go) begin done = 1; s_axi_arvalid = 1'b0; end
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    chk("rd_handshake", 32'(done), 32'd1);
    chk("rd_rvalid", 32'(s_axi_rvalid), 32'd1);
    chk("rd_rdata", s_axi_rdata, exp_d);
    chk("rd_rresp", 32'(s_axi_rresp), 32'(exp_r));
    for (int i = 0; i < r_delay; i++) begin
      tick();
      chk("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
      chk("r_hold_data", s_axi_rdata, exp_d);
      chk("r_hold_arready", 32'(s_axi_arready), 32'd0);
    end
    $display("RD addr=0x%02h rdata=0x%08h rresp=%b", a, s_axi_rdata, s_axi_rresp);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    chk("rd_rvalid_drop", 32'(s_axi_rvalid), 32'd0);
  endtask

  task automatic rd_model(input logic [4:0] a, input int r_delay);
    logic [33:0] e;
    e = model_read(a);
    rd_chk(a, e[31:0], e[33:32], r_delay);
  endtask

  task automatic strobe(input logic [1:0] eo, input logic [15:0] d);
    enable_out_i = eo; dout_i = d;
    tick();
    enable_out_i = 2'b00;
    if (eo[0]) model_strobe(d);
    $display("STROBE enable_out=%b dout=0x%04h", eo, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] e;
    logic [4:0]  a;
    logic        pre_done;

    // Reset state
    tick(); tick();
    chk("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
    chk("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
    chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_din_en", 32'({din_o, enable_in_o}), 32'd0);
    rst_i = 1'b0;
    tick();
    chk("idle_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
    for (int i = 0; i < 4; i++) rd_model(5'(i * 4), 0);

    // DIN write/read, W before AW, START pulse
    wr_chk(5'h04, 32'h0000ABCD, 4'hF, 0, 0, 0);
    rd_model(5'h04, 0);
    wr_chk(5'h00, 32'h00000001, 4'hF, 3, 0, 0);
    wr_chk(5'h00, 32'h00000001, 4'hF, 0, 2, 0);

    // DOUT capture and sticky status bits
    status_i = 2'd1;
    strobe(2'b01, 16'h1235);
    rd_model(5'h08, 0);
    rd_model(5'h0C, 0);
    strobe(2'b10, 16'h9999);
    rd_model(5'h08, 0);
    strobe(2'b01, 16'h4321);
    rd_model(5'h0C, 0);
    wr_chk(5'h0C, 32'h0000000C, 4'hF, 0, 0, 0);
    rd_model(5'h0C, 0);

    // Hardware set beats a same-cycle clear
    strobe(2'b01, 16'h0F0F);
    pre_done = m_done;
    fork
      wr_chk(5'h0C, 32'h0000000C, 4'hF, 0, 0, 0);
      begin
        enable_out_i = 2'b01; dout_i = 16'h5555;
        tick();
        enable_out_i = 2'b00;
      end
    join
    if (pre_done) m_ovr = 1'b1;
    m_done = 1'b1; m_dout = 16'h5555;
    rd_model(5'h0C, 0);
    wr_chk(5'h0C, 32'h0000000C, 4'hF, 0, 0, 0);
    rd_model(5'h0C, 0);

    // Unmapped and read-only accesses
    rd_model(5'h14, 0);
    wr_chk(5'h18, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    wr_chk(5'h08, 32'h0000FFFF, 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) rd_model(5'(i * 4), 0);

    // Back-pressure on B and R
    wr_chk(5'h04, 32'h00005A5A, 4'hF, 0, 0, 10);
    rd_model(5'h04, 10);

    // Same-cycle read and write of DIN: read sees the old value
    e = model_read(5'h04);
    fork
      wr_chk(5'h04, 32'h00001357, 4'hF, 0, 0, 0);
      rd_chk(5'h04, e[31:0], e[33:32], 0);
    join
    rd_model(5'h04, 0);

    // Byte lanes
    wr_chk(5'h04, 32'hFFFF1122, 4'h2, 0, 0, 0);
    wr_chk(5'h05, 32'hFFFF3344, 4'h1, 1, 0, 0);
    rd_model(5'h04, 0);

    // CTRL bit1
    wr_chk(5'h00, 32'h00000002, 4'hF, 0, 0, 0);
    rd_model(5'h00, 0);
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    strobe(2'b01, 16'h0001);
    tick(); tick();
    chk("irq_set", 32'(irq_o), 32'd1);
    wr_chk(5'h0C, 32'h0000000C, 4'hF, 0, 0, 0);
    tick(); tick();
    chk("irq_clear", 32'(irq_o), 32'd0);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = {3'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
          wr_chk(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        1: rd_model(5'($urandom_range(0, 31)), $urandom_range(0, 2));
        2: strobe(2'($urandom_range(0, 3)), 16'($urandom));
        default: begin
          status_i = 2'($urandom_range(0, 3));
          rd_model(5'h0C, 0);
        end
      endcase
    end

    // Reset while AW is held and W has not been sent
    s_axi_awaddr = 5'h04; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
    chk("midrst_din", 32'(din_o), 32'd0);
    #2 rst_i = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_bvalid", 32'(s_axi_bvalid), 32'd0);
      chk("midrst_din_zero", 32'(din_o), 32'd0);
    end
    for (int i = 0; i < 4; i++) rd_model(5'(i * 4), 0);
    wr_chk(5'h04, 32'h0000C0DE, 4'hF, 0, 0, 0);
    rd_model(5'h04, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
